// File: rtl/dma_pkg.sv
// Shared DMA types: streamer FSM states, burst request record and AXI constants.
package dma_pkg;

  localparam int AXI_4KB    = 4096;
  localparam int DMA_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    REQ,
    DONE,
    HOLD
  } dma_str_st_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } s_dma_burst_req_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Beats in the next INCR burst: the smallest of the remaining beats, the burst
// cap, and the beats left before the next 4 KB page boundary.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int SIZE      = 2,
  parameter int MAX_BEATS = 256,
  parameter int BEATS_W   = 9
) (
  input  logic [11:0]        page_offset,
  input  logic [ADDR_W-1:0]  rem_beats,
  output logic [BEATS_W-1:0] beats
);

  // 13 bits so a page-aligned address yields the full 4096-byte distance.
  logic [12:0]       page_bytes;
  logic [12:0]       page_beats;
  logic [ADDR_W-1:0] limit;

  // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    page_bytes = 13'(AXI_4KB) - {1'b0, page_offset};
    page_beats = page_bytes >> SIZE;
    limit      = ADDR_W'(MAX_BEATS);
    if (rem_beats < limit) limit = rem_beats;
    if (ADDR_W'(page_beats) < limit) limit = ADDR_W'(page_beats);
    beats = BEATS_W'(limit);
  end

endmodule

// File: rtl/dma_streamer.sv
// Splits the active descriptor into AXI4 INCR burst requests bounded by the
// remaining length, the burst cap and 4 KB pages; pulses done once all are accepted.
module dma_streamer
  import dma_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BEATS   = 256,
  parameter int STREAM_TYPE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              str_valid_i,
  input  logic [ADDR_W-1:0] desc_src_addr_i,
  input  logic [ADDR_W-1:0] desc_dst_addr_i,
  input  logic [ADDR_W-1:0] desc_num_bytes_i,
  output logic              str_done_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [7:0]        req_len_o,
  output logic [2:0]        req_size_o,
  output logic              busy_o
);

  localparam int BPB     = DATA_W / 8;
  localparam int SIZE    = $clog2(BPB);
  localparam int BEATS_W = $clog2(MAX_BEATS) + 1;

  dma_str_st_t        state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  rem_beats;
  logic [BEATS_W-1:0] burst_beats;
  logic [BEATS_W-1:0] beats;

  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  start_beats;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  next_rem;

  always_comb begin
    start_addr  = (STREAM_TYPE != 0) ? desc_dst_addr_i : desc_src_addr_i;
    start_addr  = start_addr & ~ADDR_W'(BPB - 1);
    // A partial trailing beat still costs a whole beat on the bus.
    start_beats = (desc_num_bytes_i >> SIZE)
                + ADDR_W'((desc_num_bytes_i & ADDR_W'(BPB - 1)) != '0);
    next_addr   = cur_addr + (ADDR_W'(burst_beats) << SIZE);
    next_rem    = rem_beats - ADDR_W'(burst_beats);
  end

  dma_burst_calc #(
    .ADDR_W    (ADDR_W),
    .SIZE      (SIZE),
    .MAX_BEATS (MAX_BEATS),
    .BEATS_W   (BEATS_W)
  ) u_burst_calc (
    .page_offset (cur_addr[11:0]),
    .rem_beats   (rem_beats),
    .beats       (beats)
  );

  assign req_size_o = 3'(SIZE);
  assign busy_o     = (state != IDLE);

  // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      rem_beats   <= '0;
      burst_beats <= '0;
      req_valid_o <= 1'b0;
      req_addr_o  <= '0;
      req_len_o   <= '0;
      str_done_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (str_valid_i) begin
            cur_addr  <= start_addr;
            rem_beats <= start_beats;
            if (desc_num_bytes_i == '0) begin
              str_done_o <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (!str_valid_i) begin
            state <= IDLE;
          end else begin
            req_addr_o  <= cur_addr;
            req_len_o   <= 8'(beats - BEATS_W'(1));
            burst_beats <= beats;
            req_valid_o <= 1'b1;
            state       <= REQ;
          end
        end

        // Request is never retracted; an abort only takes effect after the handshake.
        REQ: begin
          if (req_ready_i) begin
            req_valid_o <= 1'b0;
            cur_addr    <= next_addr;
            rem_beats   <= next_rem;
            if (!str_valid_i) begin
              state <= IDLE;
            end else if (next_rem != '0) begin
              state <= CALC;
            end else begin
              str_done_o <= 1'b1;
              state      <= DONE;
            end
          end
        end

        DONE: begin
          str_done_o <= 1'b0;
          state      <= HOLD;
        end

        HOLD: begin
          if (!str_valid_i) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
